// File: rtl/cv32e40x_pkg.sv
// Shared types and helpers for the LSU OBI responder: access size, result
// record, tracking record and the byte-lane / extraction functions.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE = 2'd0,
    LSU_SIZE_HALF = 2'd1,
    LSU_SIZE_WORD = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        bus_err;
    logic        misaligned;
  } lsu_resp_t;

  // What the response path needs to remember about each granted request.
  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      sext;
    logic [1:0] offset;
  } lsu_trk_t;

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      LSU_SIZE_HALF: return offset[0];
      LSU_SIZE_WORD: return (offset != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      LSU_SIZE_BYTE: return 4'b0001 << offset;
      LSU_SIZE_HALF: return 4'b0011 << offset;
      default:       return 4'b1111;
    endcase
  endfunction

  // Align the returned word to bit 0 and extend it to 32 bits; stores return 0.
  function automatic logic [31:0] lsu_extract(input lsu_trk_t trk, input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {trk.offset, 3'b000};
    if (trk.we) return 32'd0;
    case (trk.size)
      LSU_SIZE_BYTE: return {{24{trk.sext & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_HALF: return {{16{trk.sext & shifted[15]}}, shifted[15:0]};
      default:       return shifted;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40x_lsu_obi_responder_if.sv
// Signal bundle between EX-stage LSU requests, the OBI data bus and WB results.
// slave: the responder's view; master: the environment driving it.
interface cv32e40x_lsu_obi_responder_if;
  import cv32e40x_pkg::*;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_sext_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;

  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_bus_err_o;
  logic        resp_misaligned_o;

  modport slave (
    input  lsu_valid_i, lsu_we_i, lsu_size_i, lsu_sext_i, lsu_addr_i, lsu_wdata_i,
    output lsu_ready_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    output resp_valid_o, resp_rdata_o, resp_bus_err_o, resp_misaligned_o,
    input  resp_ready_i
  );

  modport master (
    output lsu_valid_i, lsu_we_i, lsu_size_i, lsu_sext_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_ready_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    input  resp_valid_o, resp_rdata_o, resp_bus_err_o, resp_misaligned_o,
    output resp_ready_i
  );

endinterface

// File: rtl/cv32e40x_lsu_fifo.sv
// Small first-word-fall-through FIFO with a second, lower-priority push port
// so two entries can be written in one cycle (data_i lands first).
module cv32e40x_lsu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             push2_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  always_comb begin
    pop_ok    = pop_i && (count_q != '0);
    wptr_next = ptr_inc(wptr_q);
    wptr_d    = wptr_q;
    if (push_i && push2_i) begin
      wptr_d = ptr_inc(wptr_next);
    end else if (push_i || push2_i) begin
      wptr_d = wptr_next;
    end
    rptr_d  = pop_ok ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CNT_W'(push_i) + CNT_W'(push2_i) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
    if (push2_i) begin
      mem_q[push_i ? wptr_next : wptr_q] <= data2_i;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cv32e40x_lsu_obi_responder.sv
// LSU-to-OBI bridge: issues aligned bus requests, tracks them in order and
// returns aligned/extended results (or misaligned faults) through a result FIFO.
module cv32e40x_lsu_obi_responder
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                         clk,
  input logic                         rst_n,
  cv32e40x_lsu_obi_responder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  lsu_size_e        size;
  logic [1:0]       offset;
  logic             misaligned;
  logic             credit;
  logic             grant;
  logic             mis_accept;
  logic             rvalid_pop;
  logic             rsp_pop;

  lsu_trk_t         trk_in, trk_head;
  logic             trk_full, trk_empty;
  logic [CNT_W-1:0] outstanding_cnt;

  lsu_resp_t        bus_resp, mis_resp, rsp_head;
  logic             rsp_full, rsp_empty;
  logic [CNT_W-1:0] rsp_count;

  assign size       = lsu_size_e'(bus.lsu_size_i);
  assign offset     = bus.lsu_addr_i[1:0];
  assign misaligned = lsu_misaligned(size, offset);

  // Credit deliberately ignores a pop happening in the same cycle.
  assign credit     = ({1'b0, outstanding_cnt} + {1'b0, rsp_count}) < (CNT_W + 1)'(DEPTH);

  assign bus.data_req_o   = rst_n && bus.lsu_valid_i && !misaligned && credit;
  assign bus.data_addr_o  = {bus.lsu_addr_i[31:2], 2'b00};
  assign bus.data_be_o    = lsu_be(size, offset);
  assign bus.data_wdata_o = bus.lsu_wdata_i << {offset, 3'b000};
  assign bus.data_we_o    = bus.lsu_we_i;

  assign grant           = bus.data_req_o && bus.data_gnt_i;
  assign mis_accept      = rst_n && bus.lsu_valid_i && misaligned && credit;
  assign bus.lsu_ready_o = grant || mis_accept;

  assign trk_in     = '{we: bus.lsu_we_i, size: size, sext: bus.lsu_sext_i, offset: offset};
  assign rvalid_pop = bus.data_rvalid_i && !trk_empty;

  cv32e40x_lsu_fifo #(
    .WIDTH ($bits(lsu_trk_t)),
    .DEPTH (DEPTH)
  ) u_trk_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .data_i  (trk_in),
    .push2_i (1'b0),
    .data2_i ('0),
    .pop_i   (rvalid_pop),
    .data_o  (trk_head),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .count_o (outstanding_cnt)
  );

  assign bus_resp = '{rdata: lsu_extract(trk_head, bus.data_rdata_i),
                      bus_err: bus.data_err_i, misaligned: 1'b0};
  assign mis_resp = '{rdata: 32'd0, bus_err: 1'b0, misaligned: 1'b1};
  assign rsp_pop  = bus.resp_valid_o && bus.resp_ready_i;

  // Bus responses use the primary port so they are queued ahead of a
  // misaligned fault accepted in the same cycle.
  cv32e40x_lsu_fifo #(
    .WIDTH ($bits(lsu_resp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rvalid_pop),
    .data_i  (bus_resp),
    .push2_i (mis_accept),
    .data2_i (mis_resp),
    .pop_i   (rsp_pop),
    .data_o  (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_count)
  );

  assign bus.resp_valid_o      = rst_n && !rsp_empty;
  assign bus.resp_rdata_o      = rsp_head.rdata;
  assign bus.resp_bus_err_o    = rsp_head.bus_err;
  assign bus.resp_misaligned_o = rsp_head.misaligned;

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus.data_rvalid_i |-> !trk_empty);

  a_addr_phase_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.data_req_o && !bus.data_gnt_i) |=>
      (bus.data_req_o && $stable(bus.data_addr_o) && $stable(bus.data_we_o) &&
       $stable(bus.data_be_o) && $stable(bus.data_wdata_o)));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(grant && trk_full) && !(rsp_full && (rvalid_pop || mis_accept) && !rsp_pop));

endmodule
